// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and requester indices used by the write-back arbiter.
package regfile_pkg;

  localparam int NUM_REGS   = 64;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);
  localparam int REG_DATA_W = 16;
  localparam int NUM_REQ    = 3;

  typedef logic [1:0]            req_idx_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam req_idx_t REQ_ALU  = 2'd0;
  localparam req_idx_t REQ_LOAD = 2'd1;
  localparam req_idx_t REQ_DBG  = 2'd2;

  // Round-robin successor: ALU -> LOAD -> DBG -> ALU.
  function automatic req_idx_t req_next(input req_idx_t idx);
    case (idx)
      REQ_ALU:  return REQ_LOAD;
      REQ_LOAD: return REQ_DBG;
      default:  return REQ_ALU;
    endcase
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bundle between the three requesters and the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] req_wen;
  logic [NUM_REQ-1:0] req_carry_en;
  logic [NUM_REQ-1:0] req_carry;
  reg_addr_t [NUM_REQ-1:0] req_addr;
  reg_data_t [NUM_REQ-1:0] req_data;

  modport master (
    output req_valid, req_addr, req_data, req_wen, req_carry_en, req_carry,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_wen, req_carry_en, req_carry,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_prio.sv
// Orders the three requesters for the grant walk: starved ones first by index,
// then the rest in round-robin order starting at rr.
module wb_prio_select
  import regfile_pkg::*;
(
  input  req_idx_t                   rr,
  input  logic     [NUM_REQ-1:0]     starved,
  output req_idx_t [NUM_REQ-1:0]     order
);

  logic [1:0] slot;
  req_idx_t   cand;

  always_comb begin
    order = '0;
    slot  = '0;
    cand  = rr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (starved[i]) begin
        order[slot] = req_idx_t'(i);
        slot        = slot + 2'd1;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!starved[cand]) begin
        order[slot] = cand;
        slot        = slot + 2'd1;
      end
      cand = req_next(cand);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the two register write ports and the carry write port among three
// write-back requesters; grants are combinational, commands registered.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int NREQ     = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  wb,
  output reg_addr_t            reg_wr1,
  output reg_data_t            reg_wr1_data,
  output logic                 reg_wr1_enable,
  output reg_addr_t            reg_wr2,
  output reg_data_t            reg_wr2_data,
  output logic                 reg_wr2_enable,
  output logic                 carrybit_wr,
  output logic                 carrybit_wr_enable,
  output logic [NREQ-1:0]      starve_flag
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  req_idx_t                  rr;
  logic [NREQ-1:0][3:0]      wait_cnt;
  logic [NREQ-1:0]           starved;
  req_idx_t [NUM_REQ-1:0]    order;

  logic [NREQ-1:0] grant;
  logic [1:0]      n_grant;
  req_idx_t        idx;
  req_idx_t        last_idx;
  logic            p1_use, p2_use, c_use, c_val;
  reg_addr_t       p1_addr, p2_addr;
  reg_data_t       p1_data, p2_data;

  always_comb begin
    for (int i = 0; i < NREQ; i++) starved[i] = (wait_cnt[i] == MAX_CNT);
  end

  assign starve_flag = starved;

  wb_prio_select u_prio (
    .rr      (rr),
    .starved (starved),
    .order   (order)
  );

  // Greedy walk; a same-register conflict can only involve port 1, since a
  // port-2 grant already means both slots are used.
  always_comb begin
    grant    = '0;
    n_grant  = '0;
    idx      = '0;
    last_idx = '0;
    p1_use   = 1'b0;
    p2_use   = 1'b0;
    c_use    = 1'b0;
    c_val    = 1'b0;
    p1_addr  = '0;
    p2_addr  = '0;
    p1_data  = '0;
    p2_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = order[k];
      if (!reset && wb.req_valid[idx] && n_grant != 2'd2
          && !(wb.req_wen[idx] && p1_use && wb.req_addr[idx] == p1_addr)
          && !(wb.req_carry_en[idx] && c_use)) begin
        grant[idx] = 1'b1;
        n_grant    = n_grant + 2'd1;
        last_idx   = idx;
        if (wb.req_wen[idx]) begin
          if (!p1_use) begin
            p1_use  = 1'b1;
            p1_addr = wb.req_addr[idx];
            p1_data = wb.req_data[idx];
          end else begin
            p2_use  = 1'b1;
            p2_addr = wb.req_addr[idx];
            p2_data = wb.req_data[idx];
          end
        end
        if (wb.req_carry_en[idx]) begin
          c_use = 1'b1;
          c_val = wb.req_carry[idx];
        end
      end
    end
  end

  assign wb.req_ready = grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_wr1            <= '0;
      reg_wr1_data       <= '0;
      reg_wr1_enable     <= 1'b0;
      reg_wr2            <= '0;
      reg_wr2_data       <= '0;
      reg_wr2_enable     <= 1'b0;
      carrybit_wr        <= 1'b0;
      carrybit_wr_enable <= 1'b0;
      rr                 <= REQ_ALU;
    end else begin
      reg_wr1_enable     <= p1_use;
      reg_wr2_enable     <= p2_use;
      carrybit_wr_enable <= c_use;
      if (p1_use) begin
        reg_wr1      <= p1_addr;
        reg_wr1_data <= p1_data;
      end
      if (p2_use) begin
        reg_wr2      <= p2_addr;
        reg_wr2_data <= p2_data;
      end
      if (c_use) carrybit_wr <= c_val;
      if (|grant) rr <= req_next(last_idx);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!wb.req_valid[i] || grant[i]) wait_cnt[i] <= '0;
        else if (wait_cnt[i] != MAX_CNT) wait_cnt[i] <= wait_cnt[i] + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter, checked against a
// queue-based model of the arbitration rules.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int MAX_WAIT = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [2:0]       s_valid = '0, s_wen = '0, s_cen = '0, s_c = '0;
  logic [2:0][5:0]  s_addr  = '0;
  logic [2:0][15:0] s_data  = '0;

  regfile_wb_arbiter_if bus ();
  assign bus.req_valid    = s_valid;
  assign bus.req_wen      = s_wen;
  assign bus.req_carry_en = s_cen;
  assign bus.req_carry    = s_c;
  assign bus.req_addr     = s_addr;
  assign bus.req_data     = s_data;

  logic [5:0]  reg_wr1, reg_wr2;
  logic [15:0] reg_wr1_data, reg_wr2_data;
  logic        reg_wr1_enable, reg_wr2_enable, carrybit_wr, carrybit_wr_enable;
  logic [2:0]  starve_flag;

  regfile_wb_arbiter #(.MAX_WAIT(MAX_WAIT), .NREQ(3)) dut (
    .clock              (clock),
    .reset              (reset),
    .wb                 (bus),
    .reg_wr1            (reg_wr1),
    .reg_wr1_data       (reg_wr1_data),
    .reg_wr1_enable     (reg_wr1_enable),
    .reg_wr2            (reg_wr2),
    .reg_wr2_data       (reg_wr2_data),
    .reg_wr2_enable     (reg_wr2_enable),
    .carrybit_wr        (carrybit_wr),
    .carrybit_wr_enable (carrybit_wr_enable),
    .starve_flag        (starve_flag)
  );

  int compared = 0;
  int mismatched = 0;

  int          m_cnt [3];
  int          m_rr;
  logic [2:0]  m_grant;
  int          m_gq [$];
  logic        m_wr1_en, m_wr2_en, m_c_en, m_c_val;
  logic [5:0]  m_wr1, m_wr2;
  logic [15:0] m_wr1_data, m_wr2_data;
  logic [2:0]  obs_ready;
  int          grant_tally [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_rr = 0;
    m_grant = '0;
    m_gq = {};
    m_wr1_en = 1'b0; m_wr2_en = 1'b0; m_c_en = 1'b0; m_c_val = 1'b0;
    m_wr1 = '0; m_wr2 = '0; m_wr1_data = '0; m_wr2_data = '0;
  endtask

  function automatic logic [2:0] modelStarve();
    logic [2:0] s;
    for (int i = 0; i < 3; i++) s[i] = (m_cnt[i] == MAX_WAIT);
    return s;
  endfunction

  // Priority list: starved requesters by index, then the rest from rr onwards.
  function automatic void modelGrant();
    int order [$];
    int addrs [$];
    bit carry_taken;
    bit blocked;
    int i;
    m_grant = '0;
    m_gq = {};
    carry_taken = 1'b0;
    for (int r = 0; r < 3; r++) if (m_cnt[r] == MAX_WAIT) order.push_back(r);
    for (int k = 0; k < 3; k++)
      if (m_cnt[(m_rr + k) % 3] != MAX_WAIT) order.push_back((m_rr + k) % 3);
    foreach (order[k]) begin
      i = order[k];
      if (s_valid[i]) begin
        blocked = (m_gq.size() >= 2) || (s_cen[i] && carry_taken);
        if (s_wen[i]) foreach (addrs[a]) if (addrs[a] == int'(s_addr[i])) blocked = 1'b1;
        if (!blocked) begin
          m_grant[i] = 1'b1;
          m_gq.push_back(i);
          if (s_wen[i]) addrs.push_back(int'(s_addr[i]));
          if (s_cen[i]) carry_taken = 1'b1;
        end
      end
    end
  endfunction

  function automatic void modelCommit();
    int i;
    m_wr1_en = 1'b0; m_wr2_en = 1'b0; m_c_en = 1'b0;
    foreach (m_gq[k]) begin
      i = m_gq[k];
      if (s_wen[i]) begin
        if (!m_wr1_en) begin
          m_wr1_en = 1'b1; m_wr1 = s_addr[i]; m_wr1_data = s_data[i];
        end else begin
          m_wr2_en = 1'b1; m_wr2 = s_addr[i]; m_wr2_data = s_data[i];
        end
      end
      if (s_cen[i]) begin
        m_c_en = 1'b1; m_c_val = s_c[i];
      end
    end
    if (m_gq.size() > 0) m_rr = (m_gq[m_gq.size() - 1] + 1) % 3;
    for (int r = 0; r < 3; r++) begin
      if (!s_valid[r] || m_grant[r]) m_cnt[r] = 0;
      else if (m_cnt[r] < MAX_WAIT) m_cnt[r]++;
    end
  endfunction

  task automatic applyStimulus(input int i, input logic v, input logic [5:0] a,
                               input logic [15:0] d, input logic w, input logic ce,
                               input logic c);
    s_valid[i] = v; s_addr[i] = a; s_data[i] = d;
    s_wen[i] = w; s_cen[i] = ce; s_c[i] = c;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".wr1_en"}, 32'(reg_wr1_enable), 32'(m_wr1_en));
    check({tag, ".wr2_en"}, 32'(reg_wr2_enable), 32'(m_wr2_en));
    check({tag, ".carry_en"}, 32'(carrybit_wr_enable), 32'(m_c_en));
    if (m_wr1_en) begin
      check({tag, ".wr1"}, 32'(reg_wr1), 32'(m_wr1));
      check({tag, ".wr1_data"}, 32'(reg_wr1_data), 32'(m_wr1_data));
    end
    if (m_wr2_en) begin
      check({tag, ".wr2"}, 32'(reg_wr2), 32'(m_wr2));
      check({tag, ".wr2_data"}, 32'(reg_wr2_data), 32'(m_wr2_data));
    end
    if (m_c_en) check({tag, ".carry"}, 32'(carrybit_wr), 32'(m_c_val));
    check({tag, ".starve"}, 32'(starve_flag), 32'(modelStarve()));
  endtask

  // Inputs are set at posedge+1; ready is sampled at posedge+2, outputs at next posedge+1.
  task automatic doCycle(input string tag, input int exp_ready);
    #1;
    modelGrant();
    obs_ready = bus.req_ready;
    check({tag, ".ready"}, 32'(obs_ready), 32'(m_grant));
    if (exp_ready >= 0) check({tag, ".ready_spec"}, 32'(obs_ready), exp_ready);
    for (int i = 0; i < 3; i++) if (obs_ready[i]) grant_tally[i]++;
    modelCommit();
    @(posedge clock);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    bit pending;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("reset");
    check("reset.ready", 32'(bus.req_ready), 32'h0);

    applyStimulus(0, 1, 6'd5, 16'h1234, 1, 0, 0);
    applyStimulus(1, 1, 6'd9, 16'hBEEF, 1, 0, 0);
    applyStimulus(2, 0, 6'd0, 16'h0000, 1, 0, 0);
    doCycle("indep", 3'b011);
    check("indep.wr1_spec", 32'(reg_wr1), 32'd5);
    check("indep.wr1_data_spec", 32'(reg_wr1_data), 32'h1234);
    check("indep.wr2_spec", 32'(reg_wr2), 32'd9);
    check("indep.wr2_data_spec", 32'(reg_wr2_data), 32'hBEEF);

    applyStimulus(0, 0, 6'd0, 16'h0, 1, 0, 0);
    applyStimulus(1, 0, 6'd0, 16'h0, 1, 0, 0);
    applyStimulus(2, 1, 6'd1, 16'h0ABC, 1, 0, 0);
    doCycle("align1", 3'b100);

    applyStimulus(0, 1, 6'd7, 16'h1111, 1, 0, 0);
    applyStimulus(2, 1, 6'd7, 16'h2222, 1, 0, 0);
    doCycle("addr_conflict", 3'b001);
    applyStimulus(0, 0, 6'd7, 16'h1111, 1, 0, 0);
    doCycle("addr_retry", 3'b100);
    check("addr_retry.wr1_spec", 32'(reg_wr1), 32'd7);
    check("addr_retry.data_spec", 32'(reg_wr1_data), 32'h2222);
    check("addr_retry.wr2_en_spec", 32'(reg_wr2_enable), 32'h0);

    applyStimulus(0, 1, 6'd0, 16'h0, 0, 1, 1);
    applyStimulus(1, 1, 6'd0, 16'h0, 0, 1, 0);
    applyStimulus(2, 0, 6'd0, 16'h0, 1, 0, 0);
    doCycle("carry_a", 3'b001);
    check("carry_a.val_spec", 32'(carrybit_wr), 32'h1);
    check("carry_a.wr1_en_spec", 32'(reg_wr1_enable), 32'h0);
    applyStimulus(0, 0, 6'd0, 16'h0, 0, 1, 1);
    doCycle("carry_b", 3'b010);
    check("carry_b.val_spec", 32'(carrybit_wr), 32'h0);
    check("carry_b.en_spec", 32'(carrybit_wr_enable), 32'h1);

    applyStimulus(1, 0, 6'd0, 16'h0, 1, 0, 0);
    applyStimulus(2, 1, 6'd1, 16'h0DEF, 1, 0, 0);
    doCycle("align2", 3'b100);

    for (int i = 0; i < 3; i++) begin
      grant_tally[i] = 0;
      applyStimulus(i, 1, 6'(10 + i), 16'(16'hA000 + i), 1, 0, 0);
    end
    for (int c = 0; c < 6; c++) begin
      logic [2:0] pairs [3];
      pairs[0] = 3'b011; pairs[1] = 3'b101; pairs[2] = 3'b110;
      doCycle("fair", int'(pairs[c % 3]));
    end
    for (int i = 0; i < 3; i++) check("fair.tally", 32'(grant_tally[i]), 32'd4);

    for (int i = 0; i < 3; i++) applyStimulus(i, 0, 6'd0, 16'h0, 1, 0, 0);
    doCycle("idle", 3'b000);

    for (int i = 0; i < 3; i++) applyStimulus(i, 1, 6'd3, 16'(16'hC000 + i), 1, 0, 0);
    doCycle("starve_a", 3'b001);
    check("starve_a.flag_spec", 32'(starve_flag), 32'h0);
    applyStimulus(0, 1, 6'd3, 16'hC010, 1, 0, 0);
    doCycle("starve_b", 3'b010);
    check("starve_b.flag_spec", 32'(starve_flag), 32'b100);
    applyStimulus(1, 1, 6'd3, 16'hC011, 1, 0, 0);
    doCycle("starve_c", 3'b100);
    check("starve_c.data_spec", 32'(reg_wr1_data), 32'hC002);
    applyStimulus(2, 1, 6'd3, 16'hC012, 1, 0, 0);
    doCycle("starve_d", 3'b001);

    #3;
    reset = 1'b1;
    #1;
    check("midreset.ready", 32'(bus.req_ready), 32'h0);
    check("midreset.wr1_en", 32'(reg_wr1_enable), 32'h0);
    check("midreset.wr2_en", 32'(reg_wr2_enable), 32'h0);
    check("midreset.carry_en", 32'(carrybit_wr_enable), 32'h0);
    check("midreset.starve", 32'(starve_flag), 32'h0);
    modelReset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(i, 1, 6'(20 + i), 16'(16'hD000 + i), 1, 0, 0);
    doCycle("post_reset", 3'b011);

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        pending = s_valid[i] && !m_grant[i];
        if (pending && $urandom_range(7, 0) != 0) continue;
        applyStimulus(i, 1'($urandom_range(3, 0) != 0), 6'($urandom_range(3, 0)),
                      16'($urandom), 1'($urandom_range(4, 0) != 0),
                      1'($urandom_range(2, 0) == 0), 1'($urandom_range(1, 0)));
      end
      doCycle("random", -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the register file's two write ports and its single carry-bit write port among three requesters: ALU write-back (req 0), load write-back (req 1) and debug/host access (req 2). It sits between the pipeline write-back stage and the register file. Each cycle it grants up to two requests under a rotating priority with starvation override, and drives registered write commands into the register file one cycle after acceptance.

## Interface
- MAX_WAIT, 8: wait-cycle count at which a stalled requester is forced to top priority (range 2..15).
- NREQ, 3: number of requesters (fixed at 3; the parameter is for documentation and asserts only).
- clock  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- req_valid  input  3  per-requester request valid.
- req_ready  output  3  per-requester grant, combinational. Acceptance = valid & ready in the same cycle.
- req_addr  input  3x6  destination register per requester (0..63).
- req_data  input  3x16  write data per requester.
- req_wen  input  3  request writes a register. If 0, the request is carry-only.
- req_carry_en  input  3  request also writes the carry bit.
- req_carry  input  3  carry value.
- reg_wr1, reg_wr2  output  6  register-file write addresses, registered.
- reg_wr1_data, reg_wr2_data  output  16  write data, registered.
- reg_wr1_enable, reg_wr2_enable  output  1  write enables, registered.
- carrybit_wr, carrybit_wr_enable  output  1  carry write value and enable, registered.
- starve_flag  output  3  requester i is at MAX_WAIT, registered.

## Operation
- Priority order each cycle:
  - Any requester whose wait counter equals MAX_WAIT goes first, lowest index first among several.
  - Remaining requesters follow in round-robin order starting at pointer rr (0..2).
- Greedy grant walk in priority order. A valid request is granted unless one of these holds:
  - Two grants have already been issued.
  - req_wen=1 and req_addr equals the address of an already-granted register write (same-register conflict; the later requester waits).
  - req_carry_en=1 and a carry write is already granted.
- A carry-only request (req_wen=0) consumes a grant slot but no register port.
- Port mapping: the first granted register write goes to port 1, the second to port 2.
- Granted commands are latched into the output registers. Enables not granted this cycle are cleared the next cycle.
- rr update on any grant: rr = (index of last granted requester + 1) mod 3. With no grant, rr holds.
- Wait counters (4 bits per requester):
  - Cleared on acceptance or when valid=0.
  - Incremented while valid & !ready, saturating at MAX_WAIT.
- A requester must hold addr, data and flags stable while valid & !ready. Deasserting valid without a grant is legal and clears its counter.
- Reset values: all enables 0, addresses and data 0, carrybit_wr 0, rr 0, counters 0, starve_flag 0. req_ready is 0 while reset is asserted.

## Timing
- Grant is same-cycle and combinational from req_valid, the counters and rr.
- Latency: accepted at edge N, so enables are high during cycle N+1 and the register file commits at edge N+1. Accept-to-commit is 1 cycle.
- Throughput: 2 register writes per cycle sustained, at most 1 carry write per cycle.
- Reset asserted mid-operation: all outputs clear asynchronously. An accepted command not yet presented is dropped, and requesters must reissue.
- No bypass. A read of a register in the same cycle its write is presented returns the old value; hazard handling belongs to the pipeline.
- With all three requesters valid and conflict-free, exactly two are granted. The third is guaranteed a grant within 2 cycles through rr rotation, and within MAX_WAIT cycles in the worst case.

## Structure
- Shared package regfile_pkg holds: REG_ADDR_W=6, REG_DATA_W=16, NUM_REGS=64, and requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_DBG=2.
- One sub-module, wb_prio_select: combinational priority ordering from rr and the starvation vector, outputting the 3-entry ordered index list. Grant walk, output registers and counters live in the top module.

## Test plan
- Reset: assert reset mid-cycle with all requests valid -> all enables, ready and starve_flag are 0 immediately; rr=0 after release.
- Two independent: req0 to r5=0x1234, req1 to r9=0xBEEF, rr=0 -> both ready; next cycle wr1=5/0x1234, wr2=9/0xBEEF, both enables 1; rr=2.
- Address conflict: req0 and req2 both to r7, rr=0 -> only req0 granted; req2 granted the next cycle, giving wr1=7 with req2's data.
- Carry conflict: req0 and req1 both with carry_en, values 1 and 0 -> one carry write per cycle: carrybit_wr=1, then 0 the following cycle.
- Round-robin fairness: all three valid continuously to distinct registers for 6 cycles -> grant pairs {0,1},{2,0},{1,2},... and every requester is granted 4 times.
- Starvation: MAX_WAIT=2; req0 and req1 issue back-to-back to r3, req2 also to r3 -> req2's starve_flag rises after 2 waits, and it is granted ahead of the others on the next cycle.
